// File: rtl/expr_recognizer.sv
// Streaming recogniser for ASCII arithmetic expressions with multi-digit
// operands, nested parentheses and a sticky error state.
module expr_recognizer #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7,
  parameter bit EXT_OPS    = 1'b0,
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);

  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [NDIG_W-1:0]  NDIG_MAX  = NDIG_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_EXPECT = 2'd0,
    S_NUM    = 2'd1,
    S_CLOSED = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [NDIG_W-1:0]  ndig_q, ndig_d;

  logic is_dig, is_op, is_lp, is_rp;

  always_comb begin
    is_dig = (in >= 8'd48) && (in <= 8'd57);
    is_op  = (in == 8'd43) || (in == 8'd42) ||
             (EXT_OPS && ((in == 8'd45) || (in == 8'd47)));
    is_lp  = (in == 8'd40);
    is_rp  = (in == 8'd41);
  end

  // clr wins over in_valid; an idle cycle holds every register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_EXPECT;
      depth_q <= '0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      ndig_q  <= ndig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    ndig_d  = ndig_q;
    if (in_valid) begin
      case (state_q)
        S_EXPECT: begin
          if (is_dig) begin
            state_d = S_NUM;
            ndig_d  = NDIG_W'(1);
          end else if (is_lp && (depth_q != DEPTH_MAX)) begin
            depth_d = depth_q + 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_dig && (ndig_q != NDIG_MAX)) begin
            ndig_d = ndig_q + 1'b1;
          end else if (is_op) begin
            state_d = S_EXPECT;
            ndig_d  = '0;
          end else if (is_rp && (depth_q != '0)) begin
            state_d = S_CLOSED;
            depth_d = depth_q - 1'b1;
            ndig_d  = '0;
          end else begin
            state_d = S_ERR;
          end
        end
        S_CLOSED: begin
          if (is_op) begin
            state_d = S_EXPECT;
          end else if (is_rp && (depth_q != '0)) begin
            depth_d = depth_q - 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_ERR;
      endcase
    end
  end

  // Outputs come straight from registers: one cycle after the accepting edge.
  always_comb begin
    out   = ((state_q == S_NUM) || (state_q == S_CLOSED)) && (depth_q == '0);
    err   = (state_q == S_ERR);
    depth = depth_q;
  end

endmodule
